data_mem_resp: RTL and testbench
================================

# data_mem_resp

Data-memory responder for the pipelined CPU's data port. It answers the core's MEM-stage requests (`mem_addr`, `mem_write_data`, `mem_wr`, `mem_sb`, `mem_sh`) and returns `mem_read_data` in the same cycle, so the core latches it into MEM/WB. It adds these pieces of state:
- a sequential zero-fill after reset, with a `ready` flag;
- big-endian byte and halfword store merging;
- one memory-mapped output register;
- a store counter;
- sticky error flags.

## Interface
Parameters:
- `ADDR_W`, default 10: word-address width; array depth is 2^ADDR_W words of 32 bits.
- `IO_ADDR`, default 32'hFFFF_FFF0: byte address of the memory-mapped output register.

Ports:
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-low reset.
- `mem_addr` input 32: byte address from EX/MEM.
- `mem_write_data` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `mem_wr` input 1: store request this cycle.
- `mem_sb` input 1: store byte.
- `mem_sh` input 1: store halfword.
- `mem_read_data` output 32: combinational read word.
- `ready` output 1: high once zero-fill is complete.
- `io_out` output 32: memory-mapped output register.
- `store_count` output 16: number of performed stores, saturating.
- `misalign` output 1: sticky flag, set by a misaligned store.
- `bad_addr` output 1: sticky flag, set by an out-of-range access.

## Operation
- FSM states are CLEAR and RUN, plus a clear index `clr_idx` of width ADDR_W.
- Reset (`reset`=0 at a rising edge) sets:
  - state=CLEAR, `clr_idx`=0, `ready`=0;
  - `io_out`=0, `store_count`=0, `misalign`=0, `bad_addr`=0.
- Array contents are not reset directly; the CLEAR state zeroes them.
- CLEAR:
  - Each cycle writes 0 to `mem[clr_idx]` and increments `clr_idx`.
  - At `clr_idx`=2^ADDR_W-1 it writes the final word and moves to RUN.
  - All requests are ignored and `mem_read_data`=0.
  - `bad_addr` and `misalign` do not update.
- RUN, address decode:
  - `mem_addr`==IO_ADDR selects the IO register.
  - Otherwise, bits [31:ADDR_W+2] all zero select array word `mem_addr[ADDR_W+1:2]`.
  - Anything else is out of range.
- Reads (every RUN cycle, independent of `mem_wr`):
  - Array address: `mem_read_data` = the full stored word.
  - IO address: `mem_read_data` = `io_out`.
  - Out of range: `mem_read_data` = 0; `bad_addr` is set only when `mem_wr`=1.
- Store width priority: `mem_sb` beats `mem_sh`, which beats word.
- Store byte lanes are big-endian:
  - sb: lane `mem_addr[1:0]`=0 writes bits [31:24], 1 writes [23:16], 2 writes [15:8], 3 writes [7:0]. Data comes from `mem_write_data[7:0]`.
  - sh: `mem_addr[1]`=0 writes [31:16], 1 writes [15:0]. Data comes from `mem_write_data[15:0]`.
  - word: writes all 32 bits from `mem_write_data`.
  - Unselected lanes keep their old value.
- Misaligned stores set `misalign` and are suppressed:
  - sh with `mem_addr[0]`=1;
  - word with `mem_addr[1:0]`≠0.
- IO stores:
  - Only word stores update `io_out`.
  - sb or sh to IO_ADDR sets `misalign` and is suppressed.
- Store counting:
  - Every performed store (array or IO) increments `store_count`, saturating at 16'hFFFF.
  - Suppressed and ignored stores do not count.
- Sticky flags clear only on reset.

## Timing
- Reads are combinational: `mem_read_data` depends on `mem_addr` in the same cycle. There is no read latency.
- Writes commit at the rising edge and are visible to reads in the next cycle.
- Read and write to the same address in one cycle: the read returns the old value.
- Zero-fill:
  - `ready` rises at the 2^ADDR_W-th rising edge after the first edge with `reset`=1.
  - Default ADDR_W gives 1024 cycles.
  - The first accepted request is in the cycle in which `ready`=1.
- Reset asserted mid-CLEAR or mid-RUN restarts CLEAR at index 0 on that edge. A store presented in that cycle is dropped.
- `mem_wr`=0 with `mem_sb`/`mem_sh` high: no store, no flag.
- All registered outputs change only at rising edges. `mem_read_data` is the only combinational output.

## Test plan
- **Reset and fill.** Use ADDR_W=4. Hold `reset`=0 for 2 cycles, then release. Required: `ready`=0 for 16 edges then 1; `mem_read_data`=0 for every address; `store_count`=0.
- **Word and byte merge.** Word store 32'h11223344 to 0x8, then sb 8'hAA to 0xA, then sh 16'hBEEF to 0x8. Required reads of 0x8 after each store: 32'h11223344, 32'h1122AA44, 32'hBEEFAA44. `store_count`=3.
- **Misalign and priority.**
  - sh to 0x5 and word to 0x6: array unchanged, `misalign`=1, `store_count` unchanged.
  - `mem_sb`=`mem_sh`=1 to 0x7 with data 32'h000000CC: byte lane 3 written (sb wins).
- **IO and out of range.**
  - Word 32'hDEADBEEF to IO_ADDR: `io_out`=32'hDEADBEEF next cycle; read of IO_ADDR returns it.
  - Store to 0x0001_0000: ignored, `bad_addr`=1, read returns 0.
- **Read-during-write.** Word 32'h1 then 32'h2 to 0x4 on consecutive cycles. Required: combinational read in the second cycle returns 32'h1; the following cycle returns 32'h2.
- **Reset mid-operation.**
  - Pull `reset` low at fill index 7: fill restarts and `ready` rises 16 edges after release.
  - Preload `store_count`=16'hFFFF via forced stores: it stays at 16'hFFFF on a further store.

Source files
------------

// File: rtl/data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_resp
// Purpose  : Data-memory responder for the pipelined CPU's MEM stage.
//            Combinational read, big-endian sb/sh/word store merging,
//            sequential zero-fill after reset, one memory-mapped output
//            register, saturating store counter and sticky error flags.
// Ports    : clk            - rising-edge clock
//            reset          - synchronous, active-low reset
//            mem_addr       - byte address of the request
//            mem_write_data - right-aligned store data
//            mem_wr         - store request this cycle
//            mem_sb/mem_sh  - store byte / store halfword (sb has priority)
//            mem_read_data  - combinational read word
//            ready          - zero-fill complete, requests accepted
//            io_out         - memory-mapped output register
//            store_count    - performed stores, saturating at 16'hFFFF
//            misalign       - sticky, set by a misaligned store
//            bad_addr       - sticky, set by an out-of-range store
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_resp #(
    parameter int          ADDR_W  = 10,
    parameter logic [31:0] IO_ADDR = 32'hFFFF_FFF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    input  logic        mem_wr,
    input  logic        mem_sb,
    input  logic        mem_sh,
    output logic [31:0] mem_read_data,
    output logic        ready,
    output logic [31:0] io_out,
    output logic [15:0] store_count,
    output logic        misalign,
    output logic        bad_addr
);

    localparam int               c_DEPTH    = 1 << ADDR_W;
    localparam logic             c_ST_CLEAR = 1'b0;
    localparam logic             c_ST_RUN   = 1'b1;
    localparam logic [ADDR_W-1:0] c_IDX_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] c_IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [31:0]       r_mem [0:c_DEPTH-1];
    logic              r_state;
    logic [ADDR_W-1:0] r_clr_idx;
    logic [31:0]       r_io_out;
    logic [15:0]       r_store_count;
    logic              r_misalign;
    logic              r_bad_addr;

    logic              w_next_state;
    logic              w_is_io;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_word_idx;
    logic [31:0]       w_arr_word;
    logic [31:0]       w_merged;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_widx;
    logic [31:0]       w_mem_wdata;
    logic              w_io_we;
    logic              w_store_done;
    logic              w_set_mis;
    logic              w_set_bad;

    // ------------------------------------------------------------------
    // Address decode; the IO register takes precedence over the array
    // ------------------------------------------------------------------
    assign w_is_io    = (mem_addr == IO_ADDR);
    assign w_in_range = (mem_addr[31:ADDR_W+2] == '0);
    assign w_word_idx = mem_addr[ADDR_W+1:2];
    assign w_arr_word = r_mem[w_word_idx];

    // Read path: all zero while filling or for unmapped addresses
    always_comb begin
        mem_read_data = 32'h0;
        if (r_state == c_ST_RUN) begin
            if (w_is_io) begin
                mem_read_data = r_io_out;
            end else if (w_in_range) begin
                mem_read_data = w_arr_word;
            end
        end
    end

    // Big-endian lane merge against the current (pre-write) word
    always_comb begin
        w_merged = w_arr_word;
        if (mem_sb) begin
            case (mem_addr[1:0])
                2'd0:    w_merged[31:24] = mem_write_data[7:0];
                2'd1:    w_merged[23:16] = mem_write_data[7:0];
                2'd2:    w_merged[15:8]  = mem_write_data[7:0];
                default: w_merged[7:0]   = mem_write_data[7:0];
            endcase
        end else if (mem_sh) begin
            if (mem_addr[1]) begin
                w_merged[15:0]  = mem_write_data[15:0];
            end else begin
                w_merged[31:16] = mem_write_data[15:0];
            end
        end else begin
            w_merged = mem_write_data;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and store control
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_mem_we     = 1'b0;
        w_mem_widx   = r_clr_idx;
        w_mem_wdata  = 32'h0;
        w_io_we      = 1'b0;
        w_store_done = 1'b0;
        w_set_mis    = 1'b0;
        w_set_bad    = 1'b0;
        if (r_state == c_ST_CLEAR) begin
            w_mem_we = 1'b1;
            if (r_clr_idx == c_IDX_LAST) begin
                w_next_state = c_ST_RUN;
            end
        end else if (mem_wr) begin
            if (w_is_io) begin
                // Only full-word stores may reach the output register
                if (mem_sb || mem_sh) begin
                    w_set_mis = 1'b1;
                end else begin
                    w_io_we      = 1'b1;
                    w_store_done = 1'b1;
                end
            end else if (w_in_range) begin
                if (!mem_sb && ((mem_sh && mem_addr[0]) ||
                                (!mem_sh && (mem_addr[1:0] != 2'b00)))) begin
                    w_set_mis = 1'b1;
                end else begin
                    w_mem_we     = 1'b1;
                    w_mem_widx   = w_word_idx;
                    w_mem_wdata  = w_merged;
                    w_store_done = 1'b1;
                end
            end else begin
                w_set_bad = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= c_ST_CLEAR;
            r_clr_idx     <= '0;
            r_io_out      <= 32'h0;
            r_store_count <= 16'h0;
            r_misalign    <= 1'b0;
            r_bad_addr    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == c_ST_CLEAR) begin
                r_clr_idx <= r_clr_idx + c_IDX_ONE;
            end
            if (w_io_we) begin
                r_io_out <= mem_write_data;
            end
            if (w_store_done && (r_store_count != 16'hFFFF)) begin
                r_store_count <= r_store_count + 16'd1;
            end
            if (w_set_mis) begin
                r_misalign <= 1'b1;
            end
            if (w_set_bad) begin
                r_bad_addr <= 1'b1;
            end
        end
    end

    // Array write port; contents are never reset directly, the fill zeroes them
    always_ff @(posedge clk) begin
        if (reset && w_mem_we) begin
            r_mem[w_mem_widx] <= w_mem_wdata;
        end
    end

    assign ready       = (r_state == c_ST_RUN);
    assign io_out      = r_io_out;
    assign store_count = r_store_count;
    assign misalign    = r_misalign;
    assign bad_addr    = r_bad_addr;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_resp
// Purpose  : Directed self-checking bench for data_mem_resp (ADDR_W = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_resp;

    localparam int          c_ADDR_W  = 4;
    localparam logic [31:0] c_IO_ADDR = 32'hFFFF_FFF0;

    logic        clk;
    logic        reset;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_wr;
    logic        mem_sb;
    logic        mem_sh;
    logic [31:0] mem_read_data;
    logic        ready;
    logic [31:0] io_out;
    logic [15:0] store_count;
    logic        misalign;
    logic        bad_addr;

    int checks = 0;
    int errors = 0;

    data_mem_resp #(
        .ADDR_W  (c_ADDR_W),
        .IO_ADDR (c_IO_ADDR)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_wr         (mem_wr),
        .mem_sb         (mem_sb),
        .mem_sh         (mem_sh),
        .mem_read_data  (mem_read_data),
        .ready          (ready),
        .io_out         (io_out),
        .store_count    (store_count),
        .misalign       (misalign),
        .bad_addr       (bad_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle store request, then idle the bus
    task automatic store(input logic [31:0] addr, input logic [31:0] data,
                         input logic sb, input logic sh);
        mem_addr       = addr;
        mem_write_data = data;
        mem_wr         = 1'b1;
        mem_sb         = sb;
        mem_sh         = sh;
        tick();
        mem_wr = 1'b0;
        mem_sb = 1'b0;
        mem_sh = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        mem_addr = addr;
        #1;
        check(tag, mem_read_data, exp);
    endtask

    initial begin
        reset          = 1'b0;
        mem_addr       = 32'h0;
        mem_write_data = 32'h0;
        mem_wr         = 1'b0;
        mem_sb         = 1'b0;
        mem_sh         = 1'b0;

        // ---------------- reset and fill ----------------
        tick();
        tick();
        check("rst_ready", {31'h0, ready}, 32'h0);
        check("rst_count", {16'h0, store_count}, 32'h0);
        check("rst_io", io_out, 32'h0);
        check("rst_mis", {31'h0, misalign}, 32'h0);
        check("rst_bad", {31'h0, bad_addr}, 32'h0);
        check("fill_read_zero", mem_read_data, 32'h0);
        reset = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("fill_ready", {31'h0, ready}, (i == 16) ? 32'h1 : 32'h0);
        end
        for (int i = 0; i < 16; i++) begin
            read_check("fill_zero", 32'(i * 4), 32'h0);
        end
        check("fill_count", {16'h0, store_count}, 32'h0);

        // ---------------- word and byte merge ----------------
        store(32'h8, 32'h1122_3344, 1'b0, 1'b0);
        read_check("merge_word", 32'h8, 32'h1122_3344);
        store(32'hA, 32'h0000_00AA, 1'b1, 1'b0);
        read_check("merge_sb", 32'h8, 32'h1122_AA44);
        store(32'h8, 32'h0000_BEEF, 1'b0, 1'b1);
        read_check("merge_sh", 32'h8, 32'hBEEF_AA44);
        check("merge_count", {16'h0, store_count}, 32'd3);
        check("merge_no_mis", {31'h0, misalign}, 32'h0);

        // ---------------- misalign and priority ----------------
        store(32'h5, 32'h0000_1234, 1'b0, 1'b1);
        check("mis_sh_flag", {31'h0, misalign}, 32'h1);
        read_check("mis_sh_arr", 32'h4, 32'h0);
        store(32'h6, 32'h5555_6666, 1'b0, 1'b0);
        read_check("mis_word_arr", 32'h4, 32'h0);
        check("mis_count", {16'h0, store_count}, 32'd3);
        check("mis_no_bad", {31'h0, bad_addr}, 32'h0);
        store(32'h7, 32'h0000_00CC, 1'b1, 1'b1);
        read_check("prio_sb", 32'h4, 32'h0000_00CC);
        check("prio_count", {16'h0, store_count}, 32'd4);
        // Flags present without mem_wr must not store
        mem_addr = 32'h4; mem_write_data = 32'hFFFF_FFFF; mem_sb = 1'b1;
        tick();
        mem_sb = 1'b0;
        read_check("no_wr_sb", 32'h4, 32'h0000_00CC);

        // ---------------- IO and out of range ----------------
        store(c_IO_ADDR, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check("io_out", io_out, 32'hDEAD_BEEF);
        read_check("io_read", c_IO_ADDR, 32'hDEAD_BEEF);
        check("io_count", {16'h0, store_count}, 32'd5);
        store(c_IO_ADDR, 32'h0000_0011, 1'b1, 1'b0);
        check("io_sb_supp", io_out, 32'hDEAD_BEEF);
        check("io_sb_count", {16'h0, store_count}, 32'd5);
        store(32'h0001_0000, 32'h1234_5678, 1'b0, 1'b0);
        check("oor_bad", {31'h0, bad_addr}, 32'h1);
        read_check("oor_read", 32'h0001_0000, 32'h0);
        read_check("oor_alias", 32'h0, 32'h0);
        check("oor_count", {16'h0, store_count}, 32'd5);

        // ---------------- read during write ----------------
        store(32'h4, 32'h1, 1'b0, 1'b0);
        mem_addr = 32'h4; mem_write_data = 32'h2; mem_wr = 1'b1;
        #1;
        check("rdw_old", mem_read_data, 32'h1);
        tick();
        mem_wr = 1'b0;
        #1;
        check("rdw_new", mem_read_data, 32'h2);
        check("rdw_count", {16'h0, store_count}, 32'd7);

        // ---------------- reset mid-run with a pending store ----------------
        reset = 1'b0;
        mem_addr = 32'h4; mem_write_data = 32'h99; mem_wr = 1'b1;
        tick();
        mem_wr = 1'b0;
        check("mrst_ready", {31'h0, ready}, 32'h0);
        check("mrst_count", {16'h0, store_count}, 32'h0);
        check("mrst_io", io_out, 32'h0);
        check("mrst_mis", {31'h0, misalign}, 32'h0);
        check("mrst_bad", {31'h0, bad_addr}, 32'h0);
        reset = 1'b1;
        repeat (7) tick();
        // Fill index now at 7: restart the fill
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i >= 15) begin
                check("refill_ready", {31'h0, ready}, (i == 16) ? 32'h1 : 32'h0);
            end
        end
        read_check("refill_zero", 32'h4, 32'h0);
        read_check("refill_zero8", 32'h8, 32'h0);

        // ---------------- counter saturation ----------------
        mem_addr = 32'h0; mem_write_data = 32'hA5A5_A5A5; mem_wr = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        check("sat_almost", {16'h0, store_count}, 32'h0000_FFFE);
        tick();
        check("sat_full", {16'h0, store_count}, 32'h0000_FFFF);
        tick();
        check("sat_hold", {16'h0, store_count}, 32'h0000_FFFF);
        mem_wr = 1'b0;
        read_check("sat_data", 32'h0, 32'hA5A5_A5A5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
